// File: rtl/uart_tx_halfduplex_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_halfduplex_if
// Description : Requester-side handshake and receive-status bundle for the
//               half-duplex single-wire UART.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_halfduplex_if;
  logic       send;
  logic [7:0] byte_to_send;
  logic       done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;

  // Packet sequencer side
  modport master (
    output send, byte_to_send,
    input  done, rx_data, rx_valid, rx_error
  );

  // UART side
  modport slave (
    input  send, byte_to_send,
    output done, rx_data, rx_valid, rx_error
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_halfduplex.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_halfduplex
// Description : Half-duplex 8N1 UART on a single open bus wire. Drives the
//               pin only while a frame is in flight; decodes incoming bytes
//               while the pin is released.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_halfduplex #(
  parameter int CLOCKS_PER_BIT = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  uart_tx_halfduplex_if.slave   bus,
  inout  wire                   pin
);

  localparam int c_CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST =
    c_CNT_W'(((CLOCKS_PER_BIT / 2) >= 1) ? (CLOCKS_PER_BIT / 2 - 1) : 0);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  // Mid-bit sampling is meaningless with fewer than 4 clocks per bit
  localparam logic c_RX_ENABLE = (CLOCKS_PER_BIT >= 4);

  localparam logic [1:0] c_TX_IDLE  = 2'd0;
  localparam logic [1:0] c_TX_START = 2'd1;
  localparam logic [1:0] c_TX_DATA  = 2'd2;
  localparam logic [1:0] c_TX_STOP  = 2'd3;

  localparam logic [1:0] c_RX_IDLE  = 2'd0;
  localparam logic [1:0] c_RX_START = 2'd1;
  localparam logic [1:0] c_RX_DATA  = 2'd2;
  localparam logic [1:0] c_RX_STOP  = 2'd3;

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  logic [1:0]         r_tx_state;
  logic [1:0]         w_tx_next;
  logic [c_CNT_W-1:0] r_tx_cyc;
  logic [2:0]         r_tx_bit;
  logic [7:0]         r_tx_byte;
  logic               w_tx_accept;
  logic               w_tx_bit_end;
  logic               w_pin_oe;
  logic               w_pin_out;

  assign w_tx_accept  = (r_tx_state == c_TX_IDLE) & bus.send;
  assign w_tx_bit_end = (r_tx_cyc == c_BIT_LAST);
  // Falls in the same cycle send rises so a request is never issued twice
  assign bus.done     = (r_tx_state == c_TX_IDLE) & ~bus.send;

  // TX state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_tx_state <= c_TX_IDLE;
    else          r_tx_state <= w_tx_next;
  end

  // TX next-state: one bit period per START/DATA bit/STOP
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      c_TX_IDLE:  if (bus.send) w_tx_next = c_TX_START;
      c_TX_START: if (w_tx_bit_end) w_tx_next = c_TX_DATA;
      c_TX_DATA:  if (w_tx_bit_end && (r_tx_bit == 3'd7)) w_tx_next = c_TX_STOP;
      c_TX_STOP:  if (w_tx_bit_end) w_tx_next = c_TX_IDLE;
      default:    w_tx_next = c_TX_IDLE;
    endcase
  end

  // TX outputs: pin is only ever driven outside IDLE
  always_comb begin
    w_pin_oe  = 1'b1;
    w_pin_out = 1'b1;
    case (r_tx_state)
      c_TX_IDLE:  w_pin_oe  = 1'b0;
      c_TX_START: w_pin_out = 1'b0;
      c_TX_DATA:  w_pin_out = r_tx_byte[r_tx_bit];
      c_TX_STOP:  w_pin_out = 1'b1;
      default:    w_pin_oe  = 1'b0;
    endcase
  end

  assign pin = w_pin_oe ? w_pin_out : 1'bz;

  // TX datapath: capture byte on accept, step cycle and bit counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_byte <= 8'h00;
      r_tx_cyc  <= '0;
      r_tx_bit  <= 3'd0;
    end else if (w_tx_accept) begin
      r_tx_byte <= bus.byte_to_send;
      r_tx_cyc  <= '0;
      r_tx_bit  <= 3'd0;
    end else if (r_tx_state != c_TX_IDLE) begin
      r_tx_cyc <= w_tx_bit_end ? '0 : (r_tx_cyc + c_CNT_ONE);
      if ((r_tx_state == c_TX_DATA) && w_tx_bit_end) r_tx_bit <= r_tx_bit + 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  logic               r_sync1, r_sync2, r_sync3;
  logic [1:0]         r_rx_state;
  logic [1:0]         w_rx_next;
  logic [c_CNT_W-1:0] r_rx_cyc;
  logic [2:0]         r_rx_bit;
  logic [7:0]         r_rx_shift;
  logic [7:0]         r_rx_data;
  logic               r_rx_valid;
  logic               r_rx_error;
  logic               w_rx_hold;
  logic               w_rx_fall;
  logic               w_rx_bit_end;
  logic               w_rx_shift;
  logic               w_rx_commit;

  // Including the accept edge aborts a partial reception without a pulse
  assign w_rx_hold    = ~c_RX_ENABLE | (r_tx_state != c_TX_IDLE) | w_tx_accept;
  assign w_rx_fall    = r_sync3 & ~r_sync2;
  assign w_rx_bit_end = (r_rx_cyc == c_BIT_LAST);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= pin;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // RX state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rx_state <= c_RX_IDLE;
    else          r_rx_state <= w_rx_next;
  end

  // RX next-state: half-bit start qualification, then whole-bit sampling
  always_comb begin
    w_rx_next = r_rx_state;
    if (w_rx_hold) begin
      w_rx_next = c_RX_IDLE;
    end else begin
      case (r_rx_state)
        c_RX_IDLE:  if (w_rx_fall) w_rx_next = c_RX_START;
        c_RX_START: if (r_rx_cyc == c_HALF_LAST) w_rx_next = r_sync2 ? c_RX_IDLE : c_RX_DATA;
        c_RX_DATA:  if (w_rx_bit_end && (r_rx_bit == 3'd7)) w_rx_next = c_RX_STOP;
        c_RX_STOP:  if (w_rx_bit_end) w_rx_next = c_RX_IDLE;
        default:    w_rx_next = c_RX_IDLE;
      endcase
    end
  end

  // RX outputs: data-bit sample strobe and end-of-frame commit strobe
  always_comb begin
    w_rx_shift  = 1'b0;
    w_rx_commit = 1'b0;
    if (!w_rx_hold) begin
      w_rx_shift  = (r_rx_state == c_RX_DATA) && w_rx_bit_end;
      w_rx_commit = (r_rx_state == c_RX_STOP) && w_rx_bit_end;
    end
  end

  // RX datapath: counters, shift register and result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_cyc   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_error <= 1'b0;
    end else begin
      r_rx_valid <= w_rx_commit;
      r_rx_error <= w_rx_commit & ~r_sync2;
      if (w_rx_commit) r_rx_data <= r_rx_shift;
      if (w_rx_shift)  r_rx_shift <= {r_sync2, r_rx_shift[7:1]};
      if (w_rx_hold || (r_rx_state == c_RX_IDLE)) begin
        r_rx_cyc <= '0;
        r_rx_bit <= 3'd0;
      end else if (r_rx_state == c_RX_START) begin
        r_rx_cyc <= (r_rx_cyc == c_HALF_LAST) ? '0 : (r_rx_cyc + c_CNT_ONE);
      end else begin
        r_rx_cyc <= w_rx_bit_end ? '0 : (r_rx_cyc + c_CNT_ONE);
        if (w_rx_shift) r_rx_bit <= r_rx_bit + 3'd1;
      end
    end
  end

  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_error = r_rx_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_halfduplex.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_halfduplex
// Description : Directed self-checking bench for uart_tx_halfduplex with
//               1, 4 and 8 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_halfduplex;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  // Index 0: cpb=1, 1: cpb=4, 2: cpb=8
  logic [2:0] ext_en;
  logic [2:0] ext_val;
  wire        pin1, pin4, pin8;

  int         vcnt1, vcnt4, vcnt8;
  logic [7:0] last_data8;
  logic       last_err8;

  uart_tx_halfduplex_if bus1();
  uart_tx_halfduplex_if bus4();
  uart_tx_halfduplex_if bus8();

  pullup (pin1);
  pullup (pin4);
  pullup (pin8);
  assign pin1 = ext_en[0] ? ext_val[0] : 1'bz;
  assign pin4 = ext_en[1] ? ext_val[1] : 1'bz;
  assign pin8 = ext_en[2] ? ext_val[2] : 1'bz;

  uart_tx_halfduplex #(.CLOCKS_PER_BIT(1)) u_dut1 (.clock(clk), .reset_n(rst_n), .bus(bus1), .pin(pin1));
  uart_tx_halfduplex #(.CLOCKS_PER_BIT(4)) u_dut4 (.clock(clk), .reset_n(rst_n), .bus(bus4), .pin(pin4));
  uart_tx_halfduplex #(.CLOCKS_PER_BIT(8)) u_dut8 (.clock(clk), .reset_n(rst_n), .bus(bus8), .pin(pin8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count receive pulses on every instance
  always @(negedge clk) begin
    if (bus1.rx_valid) vcnt1 = vcnt1 + 1;
    if (bus4.rx_valid) vcnt4 = vcnt4 + 1;
    if (bus8.rx_valid) begin
      vcnt8      = vcnt8 + 1;
      last_data8 = bus8.rx_data;
      last_err8  = bus8.rx_error;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pin_of(input int k);
    case (k)
      0:       return pin1;
      1:       return pin4;
      default: return pin8;
    endcase
  endfunction

  // A released pin reads 1 through the pull-up and follows an external 0
  task automatic probe_released(input string tag, input int k);
    check({tag, "_pullup"}, 32'(pin_of(k)), 32'd1);
    ext_val[k] = 1'b0;
    ext_en[k]  = 1'b1;
    #1;
    check({tag, "_extlow"}, 32'(pin_of(k)), 32'd0);
    ext_en[k]  = 1'b0;
    #1;
  endtask

  // Check 40 samples of a cpb=4 frame, starting in the cycle after accept
  task automatic check_frame4(input string tag, input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) begin
      check(tag, 32'(pin4), 32'(f[i/4]));
      tick();
    end
  endtask

  // External driver on the cpb=8 pin
  task automatic drive_frame8(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    ext_en[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ext_val[2] = f[i];
      repeat (8) tick();
    end
    ext_en[2] = 1'b0;
  endtask

  task automatic wait_rx8(input int want);
    for (int i = 0; i < 40 && vcnt8 < want; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] stream [4];
    logic       rec [$];
    logic [9:0] f;
    int         idx;
    int         k;
    bit         started;

    stream = '{8'hFF, 8'hFF, 8'hFD, 8'h00};
    n_checks = 0; n_pass = 0;
    vcnt1 = 0; vcnt4 = 0; vcnt8 = 0;
    last_data8 = 8'h00; last_err8 = 1'b0;
    ext_en = 3'b000; ext_val = 3'b111;
    rst_n = 1'b0;
    bus1.send = 1'b0; bus1.byte_to_send = 8'h00;
    bus4.send = 1'b0; bus4.byte_to_send = 8'h00;
    bus8.send = 1'b0; bus8.byte_to_send = 8'h00;

    // Reset behaviour
    #2;
    probe_released("rst_pin", 1);
    bus4.send = 1'b1; #1;
    check("rst_done_send1", 32'(bus4.done), 32'd0);
    bus4.send = 1'b0; #1;
    check("rst_done_send0", 32'(bus4.done), 32'd1);
    check("rst_rx_data", 32'(bus8.rx_data), 32'h00);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) tick();
    check("idle_done4", 32'(bus4.done), 32'd1);
    check("idle_done1", 32'(bus1.done), 32'd1);
    probe_released("idle_pin", 1);

    // Single A5 frame at cpb=4
    bus4.byte_to_send = 8'hA5;
    bus4.send = 1'b1; #1;
    check("a5_done_fall", 32'(bus4.done), 32'd0);
    tick();
    bus4.send = 1'b0;
    bus4.byte_to_send = 8'h00;
    check_frame4("a5_pin", 8'hA5);
    check("a5_done_back", 32'(bus4.done), 32'd1);
    probe_released("a5_after", 1);

    // Sequencer-style stream
    idx = 0; started = 1'b0;
    for (int c = 0; c < 300 && rec.size() < 164; c++) begin
      if (started) rec.push_back(pin4);
      bus4.send = 1'b0;
      #1;
      if (bus4.done && idx < 4) begin
        bus4.byte_to_send = stream[idx];
        bus4.send = 1'b1;
        idx++;
        started = 1'b1;
      end
      tick();
    end
    bus4.send = 1'b0;
    check("stream_len", 32'(rec.size()), 32'd164);
    check("stream_reqs", 32'(idx), 32'd4);
    k = 0;
    for (int b = 0; b < 4; b++) begin
      f = {1'b1, stream[b], 1'b0};
      for (int j = 0; j < 41; j++) begin
        if (k < rec.size()) check("stream_pin", 32'(rec[k]), (j < 40) ? 32'(f[j/4]) : 32'd1);
        k++;
      end
    end

    // cpb=1, send held through the frame, byte changed after accept
    bus1.byte_to_send = 8'h01;
    bus1.send = 1'b1;
    tick();
    bus1.byte_to_send = 8'hFF;
    f = {1'b1, 8'h01, 1'b0};
    for (int i = 0; i < 10; i++) begin
      check("cpb1_pin", 32'(pin1), 32'(f[i]));
      if (i == 4) check("cpb1_busy", 32'(bus1.done), 32'd0);
      if (i == 9) bus1.send = 1'b0;
      tick();
    end
    check("cpb1_done", 32'(bus1.done), 32'd1);
    probe_released("cpb1_after", 0);

    // Receive at cpb=8
    drive_frame8(8'h3C, 1'b1);
    wait_rx8(1);
    repeat (4) tick();
    check("rx_count1", 32'(vcnt8), 32'd1);
    check("rx_data1", 32'(last_data8), 32'h3C);
    check("rx_err1", 32'(last_err8), 32'd0);
    repeat (8) tick();
    drive_frame8(8'h3C, 1'b0);
    wait_rx8(2);
    repeat (4) tick();
    check("rx_count2", 32'(vcnt8), 32'd2);
    check("rx_data2", 32'(last_data8), 32'h3C);
    check("rx_err2", 32'(last_err8), 32'd1);

    // Reset in the middle of a frame
    bus4.byte_to_send = 8'h55;
    bus4.send = 1'b1;
    tick();
    bus4.send = 1'b0;
    repeat (10) tick();
    check("mid_pin_driven", 32'(pin4), 32'd0);
    rst_n = 1'b0;
    #1;
    probe_released("mid_rst_pin", 1);
    check("mid_rst_done", 32'(bus4.done), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_done", 32'(bus4.done), 32'd1);
    bus4.send = 1'b1;
    tick();
    bus4.send = 1'b0;
    check_frame4("post_rst_55", 8'h55);
    check("post_rst_done2", 32'(bus4.done), 32'd1);

    // Own transmissions and short bit periods never produce receive pulses
    check("no_rx4", 32'(vcnt4), 32'd0);
    check("no_rx1", 32'(vcnt1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_halfduplex.md
Name: uart_tx_halfduplex

Overview:
- Half-duplex 8N1 UART for a single-wire, Dynamixel-style TTL bus.
- Transmits one byte per `send` request on the bidirectional `pin`, and releases `pin` (high-Z) whenever it is not transmitting.
- While the line is released, a receiver decodes incoming bytes (servo status replies).
- Instantiated by the Dynamixel packet sequencer, which issues the next byte when `done` is high.

Parameters:
- clocks_per_bit, 1: clock cycles per UART bit period; must be >= 1.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- send  input  1  transmit request; sampled on each rising edge.
- byte_to_send  input  8  byte to transmit; captured on the accepting edge.
- done  output  1  transmitter idle and ready for a new request.
- pin  inout  1  single-wire bus; driven only during a transmit frame, otherwise high-Z (external pull-up).
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rx_error  output  1  one-cycle pulse with rx_valid when the stop bit was sampled as 0.

Behaviour:
- Reset (async assert, sync release):
  - TX state = IDLE, pin released (z).
  - rx_data = 0, rx_valid = 0, rx_error = 0, RX state = IDLE.
- done is combinational: done = (TX state == IDLE) & ~send.
  - done drops in the same cycle send rises, so a requester that re-asserts send whenever done is high never issues a second request before the first is accepted.
- TX accept: on a rising edge with TX IDLE and send = 1:
  - latch byte_to_send;
  - enter START;
  - clear the bit counter and the cycle counter.
- send while TX is busy is ignored; no queueing.
- TX states:
  - IDLE: pin = z.
  - START: pin driven 0.
  - DATA: pin driven to data bits LSB first; bits 0..7 each last clocks_per_bit cycles.
  - STOP: pin driven 1.
  - Then back to IDLE.
- Each of START, DATA and STOP lasts exactly clocks_per_bit cycles per bit.
  - The frame occupies 10*clocks_per_bit cycles, starting the cycle after the accepting edge.
  - The cycle counter wraps at clocks_per_bit-1; clocks_per_bit = 1 means one cycle per bit.
- The cycle after STOP completes: TX is IDLE, pin is z, and done = 1 (if send = 0).
  - If send is high in that cycle, the next frame is accepted on that edge: back-to-back frames are separated by one idle (z) cycle.
- byte_to_send may change after the accepting edge without affecting the frame in progress.
- RX input path:
  - pin is read through a 2-flop synchronizer.
  - RX is held IDLE while TX is not IDLE, so it never decodes its own transmission.
  - RX is permanently held IDLE when clocks_per_bit < 4.
- RX states:
  - IDLE: a synchronized 1->0 transition moves RX to START.
  - START: wait clocks_per_bit/2 (integer) cycles, then resample. If the line is 1 (glitch), return to IDLE; otherwise go to DATA.
  - DATA: sample every clocks_per_bit cycles for 8 bits, LSB first.
  - STOP: sample after clocks_per_bit cycles. Update rx_data, pulse rx_valid for 1 cycle, and set rx_error = ~sampled stop bit in that same cycle. Then return to IDLE.
- If TX accepts a request while RX is mid-frame:
  - RX aborts to IDLE without asserting rx_valid;
  - TX proceeds normally.
- Reset mid-frame:
  - pin is released immediately (async);
  - the frame is abandoned with no partial output;
  - done = 1 after release.

Test Plan:
- clocks_per_bit = 4, reset then idle:
  - pin = z, done = 1, rx_valid never pulses;
  - during reset_n = 0, pin = z and done = ~send.
- clocks_per_bit = 4, send 8'hA5 pulsed 1 cycle:
  - done falls in the same cycle;
  - pin shows 0, 1,0,1,0,0,1,0,1, 1, each for 4 cycles (40 cycles total), then z;
  - done returns high on the next cycle.
- Sequencer-style stream FF, FF, FD, 00, with send re-asserted whenever done = 1:
  - four complete frames in order, each separated by exactly 1 z cycle;
  - no byte lost or duplicated.
- clocks_per_bit = 1, send 8'h01:
  - pin = 0,1,0,0,0,0,0,0,0,1 on 10 consecutive cycles;
  - send held high through the frame does not restart or alter it.
- clocks_per_bit = 8, external driver sends 8'h3C on the released pin:
  - rx_valid pulses once with rx_data = 8'h3C, rx_error = 0;
  - repeating with stop bit = 0 gives rx_error = 1.
- Assert reset_n = 0 mid-frame:
  - pin goes z immediately;
  - after release, done = 1 and a new 8'h55 frame transmits correctly.
